// File: rtl/video_timing_gen.sv
// VGA raster timing generator: pixel prescaler, H/V counters, sync/DE delay line
// matching the upstream pixel pipeline, and a registered colour/sync output stage.
module video_timing_gen #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FRONT_PORCH    = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK_PORCH     = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FRONT_PORCH    = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK_PORCH     = 33,
    parameter bit HSYNC_POL        = 1'b1,
    parameter bit VSYNC_POL        = 1'b1,
    parameter int CLK_DIV          = 2,
    parameter int PIPE_DELAY       = 2,
    parameter int COLOR_BITS       = 4,
    parameter int FRAME_LEAD_LINES = 1,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [3*COLOR_BITS-1:0]   pixel_rgb,
    input  logic [YW-1:0]             irq_line,
    output logic                      next_pixel,
    output logic                      next_line,
    output logic                      next_frame,
    output logic                      vblank_pulse,
    output logic                      line_irq,
    output logic [XW-1:0]             x_pos,
    output logic [YW-1:0]             y_pos,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      vga_de
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = 3 * COLOR_BITS;

    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START    = XW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [XW-1:0] HS_END      = XW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
    localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START    = YW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [YW-1:0] VS_END      = YW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);
    localparam logic [YW-1:0] VBLANK_LINE = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] FRAME_LINE  = YW'(V_TOTAL - 1 - FRAME_LEAD_LINES);

    logic [DW-1:0] div_cnt_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          pix_en;
    logic          h_last;
    logic          v_last;

    // Raw and delayed control bits, packed as {hsync, vsync, active}
    logic [2:0]    raw_ctrl;
    logic [2:0]    dly_ctrl;

    logic          de_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic [CW-1:0] rgb_reg;

    assign pix_en = enable && (div_cnt_reg == DIV_LAST);
    assign h_last = (x_reg == H_LAST);
    assign v_last = (y_reg == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (!enable) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= pix_en ? '0 : div_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (!enable) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                x_reg <= '0;
                y_reg <= v_last ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    assign raw_ctrl[2] = (x_reg >= HS_START) && (x_reg < HS_END);
    assign raw_ctrl[1] = (y_reg >= VS_START) && (y_reg < VS_END);
    assign raw_ctrl[0] = (x_reg < H_ACT_END) && (y_reg < V_ACT_END);

    // Delay line advances per pixel so sync/DE line up with the colour arriving
    // from the upstream pipeline PIPE_DELAY pixels after its position was issued.
    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign dly_ctrl = raw_ctrl;
        end else begin : g_pipe
            logic [2:0] pipe_reg [PIPE_DELAY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) pipe_reg[i] <= 3'b000;
                end else if (!enable) begin
                    for (int i = 0; i < PIPE_DELAY; i++) pipe_reg[i] <= 3'b000;
                end else if (pix_en) begin
                    pipe_reg[0] <= raw_ctrl;
                    for (int i = 1; i < PIPE_DELAY; i++) pipe_reg[i] <= pipe_reg[i-1];
                end
            end

            assign dly_ctrl = pipe_reg[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_reg    <= 1'b0;
            rgb_reg   <= '0;
            hsync_reg <= ~HSYNC_POL;
            vsync_reg <= ~VSYNC_POL;
        end else if (!enable) begin
            de_reg    <= 1'b0;
            rgb_reg   <= '0;
            hsync_reg <= ~HSYNC_POL;
            vsync_reg <= ~VSYNC_POL;
        end else if (pix_en) begin
            de_reg    <= dly_ctrl[0];
            rgb_reg   <= dly_ctrl[0] ? pixel_rgb : '0;
            hsync_reg <= dly_ctrl[2] ? HSYNC_POL : ~HSYNC_POL;
            vsync_reg <= dly_ctrl[1] ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    // Strobes are high in the clk whose edge performs the update they describe
    assign next_pixel   = pix_en;
    assign next_line    = pix_en && h_last;
    assign vblank_pulse = next_line && (y_reg == VBLANK_LINE);
    assign next_frame   = next_line && (y_reg == FRAME_LINE);
    assign line_irq     = next_line && (y_reg == irq_line);

    assign x_pos     = x_reg;
    assign y_pos     = y_reg;
    assign vga_r     = rgb_reg[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vga_g     = rgb_reg[2*COLOR_BITS-1:COLOR_BITS];
    assign vga_b     = rgb_reg[COLOR_BITS-1:0];
    assign vga_hsync = hsync_reg;
    assign vga_vsync = vsync_reg;
    assign vga_de    = de_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster; expected pixels come
// from a pixel-count model (x = n mod H_TOTAL, y = n div H_TOTAL mod V_TOTAL).
module tb_video_timing_gen;

    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int DIV = 2, PD = 2, CB = 4, FLL = 1;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int XW = $clog2(HT), YW = $clog2(VT);
    localparam int RGBW = 3 * CB;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b1;
    logic [RGBW-1:0] pixel_rgb = '0;
    logic [YW-1:0]   irq_line = '0;
    logic            next_pixel, next_line, next_frame, vblank_pulse, line_irq;
    logic [XW-1:0]   x_pos;
    logic [YW-1:0]   y_pos;
    logic [CB-1:0]   vga_r, vga_g, vga_b;
    logic            vga_hsync, vga_vsync, vga_de;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_BACK_PORCH(HBP),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_BACK_PORCH(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CLK_DIV(DIV), .PIPE_DELAY(PD),
        .COLOR_BITS(CB), .FRAME_LEAD_LINES(FLL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_rgb(pixel_rgb),
        .irq_line(irq_line), .next_pixel(next_pixel), .next_line(next_line),
        .next_frame(next_frame), .vblank_pulse(vblank_pulse), .line_irq(line_irq),
        .x_pos(x_pos), .y_pos(y_pos), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            de;
        logic [RGBW-1:0] rgb;
        logic            hs;
        logic            vs;
    } pins_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          nl;
        logic          nf;
        logic          vb;
        logic          li;
        pins_t         pins;
    } obs_t;

    typedef struct {
        int   due;
        obs_t o;
    } entry_t;

    entry_t          sb_q[$];
    obs_t            idle_exp;
    obs_t            mon_got;
    entry_t          mon_e;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    // Model state: pixels elapsed since clear, enabled clks since clear
    int              n;
    int              en_cnt;
    logic            pix_cur;
    logic [RGBW-1:0] rgb_cur;
    pins_t           pins_now;

    function automatic pins_t pins_for(input int m, input logic [RGBW-1:0] rgb);
        pins_t p;
        int xm, ym;
        p.de  = 1'b0;
        p.rgb = '0;
        p.hs  = ~HPOL;
        p.vs  = ~VPOL;
        if (m >= 0) begin
            xm    = m % HT;
            ym    = (m / HT) % VT;
            p.hs  = (xm >= HA + HFP && xm < HA + HFP + HSW) ? HPOL : ~HPOL;
            p.vs  = (ym >= VA + VFP && ym < VA + VFP + VSW) ? VPOL : ~VPOL;
            p.de  = (xm < HA) && (ym < VA);
            p.rgb = p.de ? rgb : '0;
        end
        return p;
    endfunction

    function automatic obs_t expect_obs(input int pn, input logic pix,
                                        input logic [YW-1:0] irq, input pins_t pins);
        obs_t o;
        int xm, ym;
        logic eol;
        xm     = pn % HT;
        ym     = (pn / HT) % VT;
        eol    = pix && (xm == HT - 1);
        o.x    = XW'(xm);
        o.y    = YW'(ym);
        o.nl   = eol;
        o.vb   = eol && (ym == VA - 1);
        o.nf   = eol && (ym == VT - 1 - FLL);
        o.li   = eol && (ym == int'(irq));
        o.pins = pins;
        return o;
    endfunction

    function automatic void clear_model();
        n        = 0;
        en_cnt   = 0;
        pix_cur  = 1'b0;
        pins_now = pins_for(-1, '0);
    endfunction

    task automatic report_fail(input string name, input obs_t got, input obs_t exp);
        errors++;
        if (errors <= 40)
            $display("FAIL %s cyc=%0d got x=%0d y=%0d nl/nf/vb/li=%b%b%b%b pins=%h required x=%0d y=%0d nl/nf/vb/li=%b%b%b%b pins=%h",
                     name, cyc, got.x, got.y, got.nl, got.nf, got.vb, got.li, got.pins,
                     exp.x, exp.y, exp.nl, exp.nf, exp.vb, exp.li, exp.pins);
    endtask

    // Advance one clk: account for the edge just taken, then drive the next cycle
    task automatic step(input logic en_v, input logic rst_v, input logic [YW-1:0] irq_v);
        @(posedge clk);
        #1;
        if (!rst_n || !enable) begin
            clear_model();
        end else begin
            if (pix_cur) begin
                pins_now = pins_for(n - PD, rgb_cur);
                n++;
            end
            en_cnt++;
        end
        enable    = en_v;
        rst_n     = rst_v;
        irq_line  = irq_v;
        pixel_rgb = RGBW'($urandom);
        if (!rst_n) clear_model();
        cyc++;
        pix_cur  = enable && rst_n && ((en_cnt % DIV) == DIV - 1);
        rgb_cur  = pixel_rgb;
        idle_exp = expect_obs(n, 1'b0, irq_line, pins_now);
        if (pix_cur) sb_q.push_back('{cyc, expect_obs(n, 1'b1, irq_line, pins_now)});
    endtask

    task automatic run(input int ncyc, input logic en_v, input logic rst_v, input logic [YW-1:0] irq_v);
        for (int i = 0; i < ncyc; i++) step(en_v, rst_v, irq_v);
    endtask

    task automatic seek(input int xs, input int ys, input logic [YW-1:0] irq_v);
        int guard;
        guard = 0;
        while (!(pix_cur && (n % HT) == xs && ((n / HT) % VT) == ys) && guard < 4 * HT * VT * DIV) begin
            step(1'b1, 1'b1, irq_v);
            guard++;
        end
    endtask

    task automatic phase_done(input string name);
        $display("phase %s: cyc=%0d checks=%0d errors=%0d", name, cyc, checks, errors);
    endtask

    // Monitor: pops one expectation per presented pixel strobe, checks idle cycles otherwise
    always @(negedge clk) begin
        mon_got = {x_pos, y_pos, next_line, next_frame, vblank_pulse, line_irq,
                   vga_de, vga_r, vga_g, vga_b, vga_hsync, vga_vsync};
        checks++;
        if (next_pixel) begin
            if (sb_q.size() == 0) begin
                report_fail("unexpected_pixel", mon_got, idle_exp);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.due != cyc) report_fail("pixel_timing", mon_got, mon_e.o);
                else if (mon_got !== mon_e.o) report_fail("pixel", mon_got, mon_e.o);
            end
        end else begin
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                report_fail("missing_pixel", mon_got, mon_e.o);
            end else if (mon_got !== idle_exp) begin
                report_fail("idle", mon_got, idle_exp);
            end
        end
    end

    initial begin
        logic [YW-1:0] irq_r;
        clear_model();
        idle_exp = expect_obs(0, 1'b0, '0, pins_now);

        run(4, 1'b1, 1'b0, YW'(VA - 1));
        phase_done("reset");

        run(2 * HT * VT * DIV, 1'b1, 1'b1, YW'(VA - 1));
        phase_done("irq_at_vblank_line");

        run(2 * HT * VT * DIV, 1'b1, 1'b1, YW'(VT + 2));
        phase_done("irq_out_of_range");

        seek(5, 2, YW'(3));
        run(3, 1'b0, 1'b1, YW'(3));
        run(HT * VT * DIV, 1'b1, 1'b1, YW'(3));
        phase_done("enable_drop_mid_line");

        seek(5, 2, YW'(4));
        run(2, 1'b1, 1'b0, YW'(4));
        run(HT * VT * DIV, 1'b1, 1'b1, YW'(4));
        phase_done("rst_pulse_mid_line");

        irq_r = YW'($urandom_range(0, VT - 1));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) irq_r = YW'($urandom_range(0, (1 << YW) - 1));
            if ($urandom_range(0, 299) == 0)
                run($urandom_range(1, 4), 1'b0, 1'b1, irq_r);
            else if ($urandom_range(0, 499) == 0)
                run($urandom_range(1, 3), 1'b1, 1'b0, irq_r);
            else
                step(1'b1, 1'b1, irq_r);
        end
        phase_done("random");

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised VGA raster timing generator and output stage. It replaces the fixed 640x480@60 Hz timing block. Timing, pixel-clock division, sync polarity, pipeline compensation depth and colour depth are all generic, and it adds a runtime enable, pixel position outputs and a programmable line-compare interrupt. It sits between the composer/palette pipeline, which consumes its strobes and position, and the VGA pins.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FRONT_PORCH / H_SYNC / H_BACK_PORCH, 16 / 96 / 48, horizontal blanking segments (each ≥1)
- V_ACTIVE, 480, active lines per frame
- V_FRONT_PORCH / V_SYNC / V_BACK_PORCH, 10 / 2 / 33, vertical blanking segments (each ≥1)
- HSYNC_POL / VSYNC_POL, 1 / 1, asserted level of vga_hsync / vga_vsync
- CLK_DIV, 2, clk cycles per pixel (1..16)
- PIPE_DELAY, 2, pixel periods of sync/active delay compensating the upstream pixel pipeline (0..7)
- COLOR_BITS, 4, bits per colour channel
- FRAME_LEAD_LINES, 1, lines before frame wrap at which next_frame fires (0..V_TOTAL-1)
- Derived: H_TOTAL = sum of H terms, V_TOTAL = sum of V terms, XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- enable  in  1  run control; low = synchronous soft reset of timing
- pixel_rgb  in  3*COLOR_BITS  {R,G,B} from palette pipeline
- irq_line  in  YW  line number for line_irq
- next_pixel  out  1  pixel strobe (pix_en)
- next_line  out  1  end-of-line strobe
- next_frame  out  1  early frame-start strobe
- vblank_pulse  out  1  end of last active line strobe
- line_irq  out  1  line-compare strobe
- x_pos  out  XW  current horizontal counter
- y_pos  out  YW  current vertical counter
- vga_r / vga_g / vga_b  out  COLOR_BITS each  colour outputs
- vga_hsync / vga_vsync  out  1  sync outputs
- vga_de  out  1  delayed data-enable, aligned with colour

## Operation
- Prescaler div_cnt counts 0..CLK_DIV-1 while enable=1. pix_en = enable && (div_cnt == CLK_DIV-1). When CLK_DIV=1, pix_en = enable.
- On pix_en: x wraps at H_TOTAL-1 to 0. At h_last (x==H_TOTAL-1), y increments and wraps at V_TOTAL-1 to 0.
- Raw signals from counters:
  - hsync_raw = H_ACTIVE+H_FRONT_PORCH ≤ x < H_ACTIVE+H_FRONT_PORCH+H_SYNC
  - vsync_raw: same form using the V terms
  - active_raw = x<H_ACTIVE && y<V_ACTIVE
- hsync_raw, vsync_raw and active_raw pass through a PIPE_DELAY-stage shift register that advances only on pix_en. PIPE_DELAY=0 means no stages.
- Output register, loaded on pix_en:
  - vga_de = delayed active
  - rgb = pixel_rgb if delayed active, else 0
  - vga_hsync = delayed hsync ? HSYNC_POL : ~HSYNC_POL; vga_vsync likewise with VSYNC_POL
- Strobes are combinational from state, one clk wide, asserted only when pix_en=1:
  - next_pixel = pix_en
  - next_line = pix_en && h_last
  - vblank_pulse = next_line && y==V_ACTIVE-1
  - next_frame = next_line && y==(V_TOTAL-1-FRAME_LEAD_LINES)
  - line_irq = next_line && y==irq_line; irq_line ≥ V_TOTAL never fires
- Simultaneous strobes are independent; e.g. with irq_line=V_ACTIVE-1, line_irq and vblank_pulse fire together.
- x_pos / y_pos mirror the counters directly.
- enable low:
  - On the next clk, div_cnt, counters and pipeline clear, and every output takes its reset value.
  - While low, all strobes stay 0.
  - On re-enable, timing starts at x=0, y=0, with the first pix_en CLK_DIV clks after enable rises.
- rst_n low (any time, including mid-frame): the same state as enable low, applied asynchronously.
- Reset values:
  - counters, div_cnt, rgb, vga_de, all strobes = 0
  - vga_hsync = ~HSYNC_POL, vga_vsync = ~VSYNC_POL
  - pipeline stages = inactive

## Timing
- Pixel period = CLK_DIV clks; line = H_TOTAL pixels; frame = H_TOTAL*V_TOTAL pixels.
- Counter state to pin latency: PIPE_DELAY+1 pixel periods. Pixel_rgb sampled on a pix_en edge is on the pins from the following clk.
- Upstream must present the colour for counter position (x,y) on pixel_rgb on the pix_en edge PIPE_DELAY pixels later.
- Strobes precede the counter update they describe by zero clks: they are high in the clk whose edge performs the wrap.
- irq_line is sampled combinationally; changes take effect immediately.

## Test plan
- Defaults, release rst_n with enable=1 → next_pixel every 2 clks; first next_line 1600 clks after the first pix_en edge window; next_line period 1600 clks, width 1 clk.
- Defaults → vga_hsync high for exactly 96 pixel periods, rising 3 pixels after x reaches 656; vga_vsync high 2 lines; vga_de high 640 pixels per line on 480 lines.
- Defaults → vblank_pulse once per frame at y=479,x=799; next_frame at y=523,x=799; frame period 840000 clks.
- irq_line=100 → exactly one line_irq per frame, coincident with next_line at y=100; irq_line=600 → none over 2 frames.
- Deassert enable mid-line at x=300,y=20 → all outputs at reset values next clk, strobes silent; re-enable → x_pos=0,y_pos=0, normal sequence resumes. Repeat using rst_n pulse.
- CLK_DIV=1, PIPE_DELAY=0, HSYNC_POL=0 → pixel_rgb=0xABC in active area appears on vga_r/g/b one clk later, 0 in blanking; vga_hsync low during sync, high otherwise.
